// File: rtl/traffic_phase_ctrl.sv
// N-road traffic-light phase controller: round-robin green among demanding roads,
// min/max green, timed yellow and all-red clearance, emergency pre-emption.
module traffic_phase_ctrl #(
    parameter int N_ROADS   = 4,
    parameter int CLK_DIV   = 50000000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_ROADS-1:0]           sensor_i,
    input  logic                         preempt_i,
    // One bit wider than a road index so out-of-range requests can be expressed and rejected
    input  logic [$clog2(N_ROADS):0]     preempt_road_i,
    output logic [3*N_ROADS-1:0]         lights_o,
    output logic [1:0]                   phase_o,
    output logic [$clog2(N_ROADS)-1:0]   active_road_o,
    output logic                         tick_o
);

    localparam int RW = $clog2(N_ROADS);
    localparam int PW = RW + 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

    logic [DW-1:0]        presc_q, presc_d;
    logic                 tick_q;
    phase_e               phase_q, phase_d;
    logic [RW-1:0]        active_q, active_d;
    logic [RW-1:0]        next_q, next_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [3*N_ROADS-1:0] lights_q, lights_d;

    logic                 cand_found;
    logic [RW-1:0]        cand_road;
    logic [N_ROADS-1:0]   hit;
    logic [RW-1:0]        rot_idx [N_ROADS];
    logic                 pre_valid, pre_other, pre_hold;
    logic [RW-1:0]        pre_road;
    logic                 gap_out, max_out;

    // Free-running prescaler; tick is registered so it reads 0 during reset
    always_comb begin
        presc_d = (presc_q == DW'(CLK_DIV - 1)) ? '0 : presc_q + 1'b1;
    end

    // Candidate search: rot_idx[k] is the road k steps after the active one
    generate
        for (genvar gi = 0; gi < N_ROADS; gi++) begin : g_rot
            assign rot_idx[gi] = RW'((int'(active_q) + gi) % N_ROADS);
            if (gi == 0) begin : g_self
                assign hit[gi] = 1'b0;
            end else begin : g_other
                assign hit[gi] = sensor_i[rot_idx[gi]];
            end
        end
    endgenerate

    always_comb begin
        cand_found = |hit;
        cand_road  = active_q;
        for (int k = N_ROADS - 1; k >= 1; k--) begin
            if (hit[k]) begin
                cand_road = rot_idx[k];
            end
        end
    end

    always_comb begin
        pre_valid = preempt_i && (preempt_road_i < PW'(N_ROADS));
        pre_road  = preempt_road_i[RW-1:0];
        pre_other = pre_valid && (pre_road != active_q);
        pre_hold  = pre_valid && (pre_road == active_q);
        gap_out   = (timer_q >= CNT_W'(GREEN_MIN)) && !sensor_i[active_q] && cand_found;
        max_out   = (timer_q >= CNT_W'(GREEN_MAX)) && cand_found;
    end

    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        next_d   = next_q;
        case (phase_q)
            PH_GREEN: begin
                if (pre_other) begin
                    phase_d = PH_YELLOW;
                    next_d  = pre_road;
                end else if (!pre_hold && (gap_out || max_out)) begin
                    phase_d = PH_YELLOW;
                    next_d  = cand_road;
                end
            end
            PH_YELLOW: begin
                if (pre_valid) begin
                    next_d = pre_road;
                end
                if (tick_q && (timer_q == CNT_W'(YELLOW_T - 1))) begin
                    phase_d = PH_ALLRED;
                end
            end
            PH_ALLRED: begin
                if (pre_valid) begin
                    next_d = pre_road;
                end
                if (tick_q && (timer_q == CNT_W'(ALLRED_T - 1))) begin
                    phase_d  = PH_GREEN;
                    active_d = next_d;
                end
            end
            default: begin
                phase_d = PH_ALLRED;
            end
        endcase
    end

    // A phase change always restarts the timer, even if a tick lands in the same cycle
    always_comb begin
        if (phase_d != phase_q) begin
            timer_d = '0;
        end else if (tick_q && (timer_q != {CNT_W{1'b1}})) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    generate
        for (genvar gi = 0; gi < N_ROADS; gi++) begin : g_lamp
            assign lights_d[3*gi +: 3] =
                (active_d != RW'(gi))    ? 3'b100 :
                (phase_d == PH_GREEN)    ? 3'b001 :
                (phase_d == PH_YELLOW)   ? 3'b010 : 3'b100;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q  <= '0;
            tick_q   <= 1'b0;
            phase_q  <= PH_ALLRED;
            active_q <= '0;
            next_q   <= '0;
            timer_q  <= '0;
            lights_q <= {N_ROADS{3'b100}};
        end else begin
            presc_q  <= presc_d;
            tick_q   <= (presc_d == DW'(CLK_DIV - 1));
            phase_q  <= phase_d;
            active_q <= active_d;
            next_q   <= next_d;
            timer_q  <= timer_d;
            lights_q <= lights_d;
        end
    end

    assign lights_o      = lights_q;
    assign phase_o       = phase_q;
    assign active_road_o = active_q;
    assign tick_o        = tick_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: reset, pre-emption, mid-phase reset,
// a round-robin vector table and a long no-competition hold.
module tb_traffic_phase_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sensor = '0;
    logic        preempt = 1'b0;
    logic [2:0]  preempt_road = '0;
    logic [11:0] lights;
    logic [1:0]  phase;
    logic [1:0]  active_road;
    logic        tick;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] sensor;
        logic       preempt;
        logic [2:0] proad;
        logic [1:0] exp_road;
        int         exp_gt;
    } vec_t;

    vec_t vecs [7];

    traffic_phase_ctrl #(
        .N_ROADS(4), .CLK_DIV(4), .GREEN_MIN(2), .GREEN_MAX(5),
        .YELLOW_T(1), .ALLRED_T(1), .CNT_W(8)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sensor_i       (sensor),
        .preempt_i      (preempt),
        .preempt_road_i (preempt_road),
        .lights_o       (lights),
        .phase_o        (phase),
        .active_road_o  (active_road),
        .tick_o         (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] lights_for(input logic [1:0] ph, input logic [1:0] rd);
        logic [11:0] l;
        l = 12'h924;
        if (ph == 2'd0)      l[3*rd +: 3] = 3'b001;
        else if (ph == 2'd1) l[3*rd +: 3] = 3'b010;
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From a GREEN sample, follow green -> yellow -> all-red -> green, counting ticks per phase
    task automatic run_to_green(input logic [1:0] old_road, input logic [1:0] exp_road,
                                input int exp_gt, input string tag);
        int gt, yt, at, cyc;
        gt = 0; yt = 0; at = 0;
        cyc = 0;
        while (phase == 2'd0 && cyc < 100) begin
            if (tick) gt++;
            step();
            cyc++;
        end
        chk($sformatf("%s yellow entry", tag), 32'(phase), 32'd1);
        chk($sformatf("%s yellow lights", tag), 32'(lights), 32'(lights_for(2'd1, old_road)));
        chk($sformatf("%s green ticks", tag), gt, exp_gt);
        cyc = 0;
        while (phase == 2'd1 && cyc < 100) begin
            if (tick) yt++;
            step();
            cyc++;
        end
        chk($sformatf("%s yellow ticks", tag), yt, 1);
        chk($sformatf("%s allred lights", tag), 32'(lights), 32'h924);
        cyc = 0;
        while (phase == 2'd2 && cyc < 100) begin
            if (tick) at++;
            step();
            cyc++;
        end
        chk($sformatf("%s allred ticks", tag), at, 1);
        chk($sformatf("%s green phase", tag), 32'(phase), 32'd0);
        chk($sformatf("%s next road", tag), 32'(active_road), 32'(exp_road));
        chk($sformatf("%s green lights", tag), 32'(lights), 32'(lights_for(2'd0, exp_road)));
        $display("%s: road %0d -> road %0d, green %0d ticks, yellow %0d, allred %0d",
                 tag, old_road, active_road, gt, yt, at);
    endtask

    initial begin
        int cyc, nongreen, nticks;
        logic [1:0] prev;

        vecs[0] = '{4'b0100, 1'b0, 3'd0, 2'd2, 2};
        vecs[1] = '{4'b0011, 1'b0, 3'd0, 2'd0, 2};
        vecs[2] = '{4'b1001, 1'b0, 3'd0, 2'd3, 5};
        vecs[3] = '{4'b0110, 1'b0, 3'd0, 2'd1, 2};
        vecs[4] = '{4'b1010, 1'b0, 3'd0, 2'd3, 5};
        vecs[5] = '{4'b0101, 1'b1, 3'd2, 2'd2, 0};
        vecs[6] = '{4'b0001, 1'b1, 3'd5, 2'd0, 2};

        // Reset and release
        repeat (10) step();
        chk("reset lights", 32'(lights), 32'h924);
        chk("reset phase", 32'(phase), 32'd2);
        chk("reset tick", 32'(tick), 32'd0);
        chk("reset active", 32'(active_road), 32'd0);
        rst_n = 1'b1;
        cyc = 0;
        while (phase != 2'd0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("release to green cycles", cyc, 4);
        chk("release road0 green", 32'(lights[2:0]), 32'd1);
        chk("release active", 32'(active_road), 32'd0);
        $display("reset: road 0 green after %0d cycles", cyc);

        // Pre-emption to road 1 at timer 0
        preempt = 1'b1;
        preempt_road = 3'd1;
        step();
        chk("preempt next-cycle yellow", 32'(phase), 32'd1);
        run_to_green(2'd0, 2'd1, 0, "preempt r1");

        // Pre-emption retargeted from road 2 to road 3 during all-red
        preempt_road = 3'd2;
        step();
        chk("preempt r2 yellow", 32'(lights), 32'(lights_for(2'd1, 2'd1)));
        cyc = 0;
        while (phase == 2'd1 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("preempt r2 allred", 32'(phase), 32'd2);
        preempt_road = 3'd3;
        cyc = 0;
        while (phase == 2'd2 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("preempt retarget green", 32'(phase), 32'd0);
        chk("preempt retarget road", 32'(active_road), 32'd3);
        $display("preempt retarget: road %0d green", active_road);
        preempt = 1'b0;
        preempt_road = 3'd0;

        // Reset asserted during yellow
        sensor = 4'b0001;
        cyc = 0;
        while (phase == 2'd0 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("midreset yellow reached", 32'(phase), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset async lights", 32'(lights), 32'h924);
        chk("midreset async phase", 32'(phase), 32'd2);
        chk("midreset async active", 32'(active_road), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
        while (phase != 2'd0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("midreset regain cycles", cyc, 4);
        chk("midreset regain road", 32'(active_road), 32'd0);
        $display("midreset: road %0d green after %0d cycles", active_road, cyc);

        // Round-robin / gap-out / max-out / pre-emption table
        prev = 2'd0;
        for (int i = 0; i < 7; i++) begin
            sensor       = vecs[i].sensor;
            preempt      = vecs[i].preempt;
            preempt_road = vecs[i].proad;
            run_to_green(prev, vecs[i].exp_road, vecs[i].exp_gt, $sformatf("vec%0d", i));
            prev = vecs[i].exp_road;
        end
        preempt = 1'b0;
        preempt_road = 3'd0;

        // No competing demand: green holds
        sensor = 4'b0000;
        nongreen = 0;
        nticks = 0;
        repeat (20) begin
            step();
            if (phase != 2'd0) nongreen++;
        end
        sensor = 4'b0001;
        cyc = 0;
        while (nticks < 100 && cyc < 1000) begin
            step();
            cyc++;
            if (phase != 2'd0) nongreen++;
            if (tick) nticks++;
        end
        chk("hold never left green", nongreen, 0);
        chk("hold tick count", nticks, 100);
        chk("hold road", 32'(active_road), 32'd0);
        chk("hold lights", 32'(lights), 32'(lights_for(2'd0, 2'd0)));
        $display("hold: road %0d green for %0d ticks, %0d non-green cycles", active_road, nticks, nongreen);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
